// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector lane sequencer.
package vec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    localparam logic OP_VV = 1'b1;
    localparam logic OP_VS = 1'b0;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/lane_slice_mux.sv
// Selects the LANES-wide slice of a captured vector for one beat; lane k carries
// element k*BEATS+beat, zero with in_range_o[k]=0 when that element is padding.
module lane_slice_mux #(
    parameter int L     = 8,
    parameter int V     = 20,
    parameter int LANES = 4,
    parameter int BEATS = 5,
    parameter int BW    = 3
) (
    input  logic [V*L-1:0]     vec_i,
    input  logic [BW-1:0]      beat_i,
    output logic [LANES*L-1:0] slice_o,
    output logic [LANES-1:0]   in_range_o
);

    // Table sized to the full beat index range so every beat value selects a defined slot.
    localparam int SLOTS = 1 << BW;

    genvar k, b;
    for (k = 0; k < LANES; k++) begin : g_lane
        logic [L-1:0]     col_s [SLOTS];
        logic [SLOTS-1:0] rng_s;

        for (b = 0; b < SLOTS; b++) begin : g_slot
            if ((b < BEATS) && ((k * BEATS + b) < V)) begin : g_live
                assign col_s[b] = vec_i[(k * BEATS + b) * L +: L];
                assign rng_s[b] = 1'b1;
            end else begin : g_pad
                assign col_s[b] = {L{1'b0}};
                assign rng_s[b] = 1'b0;
            end
        end

        assign slice_o[k * L +: L] = col_s[beat_i];
        assign in_range_o[k]       = rng_s[beat_i];
    end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Captures A/B operand vectors and issues them to a LANES-wide ALU over BEATS beats.
// Optional per-element masking is enabled by defining SEQ_MASK_EN.
module vector_lane_sequencer
    import vec_pkg::*;
#(
    parameter int N     = 32,
    parameter int L     = 8,
    parameter int V     = 20,
    parameter int LANES = 4,
    localparam int BEATS = ceil_div(V, LANES),
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start_i,
    input  logic [1:0]         OpType,
    input  logic [V*L-1:0]     RD1_VEC_i,
    input  logic [V*L-1:0]     RD2_VEC_i,
    input  logic [N-1:0]       Scalar_i,
`ifdef SEQ_MASK_EN
    input  logic [V-1:0]       mask_i,
`endif
    output logic               start_ready_o,
    output logic [LANES*L-1:0] Vec_A_o,
    output logic [LANES*L-1:0] Vec_B_o,
    output logic [LANES-1:0]   lane_en_o,
    output logic [BW-1:0]      beat_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    seq_state_e       state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [V*L-1:0]   a_q, a_d;
    logic [V*L-1:0]   b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [LANES*L-1:0] a_slice_s, b_slice_s;
    logic [LANES-1:0] a_rng_s, b_rng_s;
    logic [LANES-1:0] mask_lane_s;
    logic             last_beat_s;
    logic             unused_s;

    assign last_beat_s = (beat_q == BW'(BEATS - 1));

`ifdef SEQ_MASK_EN
    logic [V-1:0]     mask_q, mask_d;
    logic [LANES-1:0] mask_rng_s;
`endif

    // Next-state, beat advance and operand capture.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
`ifdef SEQ_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    beat_d  = {BW{1'b0}};
                    a_d     = RD1_VEC_i;
                    b_d     = (OpType[0] == OP_VV) ? RD2_VEC_i : {V{Scalar_i[L-1:0]}};
                    op_d    = OpType;
`ifdef SEQ_MASK_EN
                    mask_d  = mask_i;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // start_i is deliberately not looked at here; only the ALU handshake moves us.
                if (out_ready_i) begin
                    if (last_beat_s) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            beat_q  <= {BW{1'b0}};
            a_q     <= {(V*L){1'b0}};
            b_q     <= {(V*L){1'b0}};
            op_q    <= 2'b00;
`ifdef SEQ_MASK_EN
            mask_q  <= {V{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
`ifdef SEQ_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    lane_slice_mux #(.L(L), .V(V), .LANES(LANES), .BEATS(BEATS), .BW(BW)) u_mux_a (
        .vec_i      (a_q),
        .beat_i     (beat_q),
        .slice_o    (a_slice_s),
        .in_range_o (a_rng_s)
    );

    lane_slice_mux #(.L(L), .V(V), .LANES(LANES), .BEATS(BEATS), .BW(BW)) u_mux_b (
        .vec_i      (b_q),
        .beat_i     (beat_q),
        .slice_o    (b_slice_s),
        .in_range_o (b_rng_s)
    );

`ifdef SEQ_MASK_EN
    lane_slice_mux #(.L(1), .V(V), .LANES(LANES), .BEATS(BEATS), .BW(BW)) u_mux_mask (
        .vec_i      (mask_q),
        .beat_i     (beat_q),
        .slice_o    (mask_lane_s),
        .in_range_o (mask_rng_s)
    );
    assign unused_s = ^{op_q[1], Scalar_i, b_rng_s, mask_rng_s};
`else
    assign mask_lane_s = {LANES{1'b1}};
    assign unused_s    = ^{op_q[1], Scalar_i, b_rng_s};
`endif

    assign start_ready_o = (state_q == IDLE);
    assign out_valid_o   = (state_q == ISSUE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign beat_o        = beat_q;
    assign Vec_A_o       = a_slice_s;
    // Scalar broadcast reaches padded lanes too, so it bypasses the slice mux.
    assign Vec_B_o       = (op_q[0] == OP_VV) ? b_slice_s : {LANES{b_q[L-1:0]}};
    assign lane_en_o     = out_valid_o ? (a_rng_s & mask_lane_s) : {LANES{1'b0}};

endmodule
